// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, bus ACK levels and the address width.
// The I2C master imports this package as well.
package i2c_pkg;

    localparam int   I2C_ADDR_W = 7;
    localparam logic I2C_ACK    = 1'b0;
    localparam logic I2C_NACK   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WR_DATA   = 3'd3,
        ST_WR_ACK    = 3'd4,
        ST_RD_DATA   = 3'd5,
        ST_RD_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-stage synchronizer for a raw pin, followed by a one-cycle rise/fall detector.
// Resets to the idle-high bus level so no edge is reported when reset is released.
module i2c_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target answering one fixed 7-bit address: ACKs and delivers written bytes,
// requests and shifts out bytes on reads. SDA is only ever changed after an SCL fall.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] DEV_ADDR    = 7'h42,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       addressed,
    output logic       busy,
    output state_t     state_dbg
);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;
    logic start, stop;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk), .rst_n(rst_n), .d_i(scl_in),
        .level_o(scl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk), .rst_n(rst_n), .d_i(sda_in),
        .level_o(sda), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    assign start = sda_fall & scl;
    assign stop  = sda_rise & scl;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       addressed_q, addressed_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;
    // In ACK states: ACK already driven. In RD_DATA: a fresh tx_data load is pending.
    logic       phase_q, phase_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            tx_shift_q  <= 8'h00;
            rx_data_q   <= 8'h00;
            sda_oe_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            addressed_q <= 1'b0;
            busy_q      <= 1'b0;
            rw_q        <= 1'b0;
            phase_q     <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            sda_oe_q    <= sda_oe_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            addressed_q <= addressed_d;
            busy_q      <= busy_d;
            rw_q        <= rw_d;
            phase_q     <= phase_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        sda_oe_d    = sda_oe_q;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        addressed_d = addressed_q;
        busy_d      = busy_q;
        rw_d        = rw_q;
        phase_d     = phase_q;

        if (stop) begin
            state_d     = ST_IDLE;
            sda_oe_d    = 1'b0;
            addressed_d = 1'b0;
            busy_d      = 1'b0;
            phase_d     = 1'b0;
        end else if (start) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = 3'd0;
            sda_oe_d    = 1'b0;
            addressed_d = 1'b0;
            busy_d      = 1'b1;
            phase_d     = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            phase_d = 1'b0;
                            if (state_q == ST_WR_DATA) begin
                                rx_data_d  = {shift_q[6:0], sda};
                                rx_valid_d = 1'b1;
                                state_d    = ST_WR_ACK;
                            end else if (shift_q[6:0] == DEV_ADDR) begin
                                rw_d     = sda;
                                tx_req_d = sda;
                                state_d  = ST_ADDR_ACK;
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = ~I2C_ACK;
                            phase_d  = 1'b1;
                            if (state_q == ST_ADDR_ACK) addressed_d = 1'b1;
                        end else begin
                            phase_d   = 1'b0;
                            bit_cnt_d = 3'd0;
                            if (state_q == ST_ADDR_ACK && rw_q) begin
                                sda_oe_d   = ~tx_data[7];
                                tx_shift_d = {tx_data[6:0], 1'b0};
                                state_d    = ST_RD_DATA;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = ST_WR_DATA;
                            end
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        if (phase_q) begin
                            sda_oe_d   = ~tx_data[7];
                            tx_shift_d = {tx_data[6:0], 1'b0};
                            phase_d    = 1'b0;
                        end else if (bit_cnt_q == 3'd7) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            state_d   = ST_RD_ACK;
                        end else begin
                            sda_oe_d   = ~tx_shift_q[7];
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                            bit_cnt_d  = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda == I2C_ACK) begin
                            tx_req_d  = 1'b1;
                            phase_d   = 1'b1;
                            bit_cnt_d = 3'd0;
                            state_d   = ST_RD_DATA;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                ST_WAIT_STOP: sda_oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        sda_oe    = sda_oe_q;
        rx_data   = rx_data_q;
        rx_valid  = rx_valid_q;
        tx_req    = tx_req_q;
        addressed = addressed_q;
        busy      = busy_q;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged master on a wired-AND SDA line,
// pulse counters for rx_valid/tx_req, and a queue that answers tx_req.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int H = 8;  // clk cycles per SCL half phase step

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req;
    logic       addressed;
    logic       busy;
    state_t     state_dbg;

    int vectors = 0;
    int miscompares = 0;
    int rx_cnt = 0;
    int tx_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];

    assign sda_line = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target #(.DEV_ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .scl_in(m_scl), .sda_in(sda_line),
        .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_req(tx_req), .addressed(addressed),
        .busy(busy), .state_dbg(state_dbg)
    );

    // Pulse observers; tx_req is answered with the next queued byte.
    initial forever begin
        @(negedge clk);
        if (rx_valid === 1'b1) rx_cnt++;
        if (tx_req === 1'b1) begin
            tx_cnt++;
            if (tx_q.size() > 0) tx_data = tx_q.pop_front();
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b0; wait_clks(H);
        m_scl = 1'b0; wait_clks(H);
    endtask

    task automatic i2c_rstart();
        m_sda = 1'b1; wait_clks(H);
        m_scl = 1'b1; wait_clks(H);
        m_sda = 1'b0; wait_clks(H);
        m_scl = 1'b0; wait_clks(H);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clks(H);
        m_scl = 1'b1; wait_clks(H);
        m_sda = 1'b1; wait_clks(H);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    wait_clks(H);
        m_scl = 1'b1; wait_clks(H);
        m_scl = 1'b0; wait_clks(H);
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; wait_clks(H);
        m_scl = 1'b1; wait_clks(H / 2);
        b = sda_line; wait_clks(H / 2);
        m_scl = 1'b0; wait_clks(H);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic master_ack);
        for (int i = 7; i >= 0; i--) recv_bit(d[i]);
        send_bit(master_ack ? I2C_ACK : I2C_NACK);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         rx0, tx0;

        // Reset state
        wait_clks(4);
        check("rst_sda_oe", {7'd0, sda_oe}, 8'h00);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", {7'd0, rx_valid}, 8'h00);
        check("rst_tx_req", {7'd0, tx_req}, 8'h00);
        check("rst_addressed", {7'd0, addressed}, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        check("rst_state", {5'd0, state_dbg}, {5'd0, ST_IDLE});
        rst_n = 1'b1;
        wait_clks(4);

        // Write 0x42/W, data A5, STOP
        rx0 = rx_cnt;
        i2c_start();
        check("t1_busy_after_start", {7'd0, busy}, 8'h01);
        write_byte(8'h84, ack);
        check("t1_addr_ack", {7'd0, ack}, 8'h00);
        check("t1_addressed", {7'd0, addressed}, 8'h01);
        write_byte(8'hA5, ack);
        check("t1_data_ack", {7'd0, ack}, 8'h00);
        check("t1_rx_data", rx_data, 8'hA5);
        check("t1_rx_pulses", 8'(rx_cnt - rx0), 8'd1);
        i2c_stop();
        check("t1_busy_after_stop", {7'd0, busy}, 8'h00);
        check("t1_addressed_after_stop", {7'd0, addressed}, 8'h00);
        check("t1_state", {5'd0, state_dbg}, {5'd0, ST_IDLE});

        // Read 0x42/R: 3C (master ACK), C3 (master NACK)
        tx0 = tx_cnt;
        tx_q.push_back(8'h3C);
        tx_q.push_back(8'hC3);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        i2c_start();
        write_byte(8'h85, ack);
        check("t2_addr_ack", {7'd0, ack}, 8'h00);
        read_byte(d, 1'b1);
        check("t2_byte0", d, exp_q.pop_front());
        read_byte(d, 1'b0);
        check("t2_byte1", d, exp_q.pop_front());
        check("t2_tx_req_pulses", 8'(tx_cnt - tx0), 8'd2);
        check("t2_sda_released", {7'd0, sda_oe}, 8'h00);
        check("t2_state_after_nack", {5'd0, state_dbg}, {5'd0, ST_WAIT_STOP});
        i2c_stop();
        check("t2_busy_after_stop", {7'd0, busy}, 8'h00);

        // Wrong address 0x43: no ACK, following byte ignored
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'h86, ack);
        check("t3_addr_nack", {7'd0, ack}, 8'h01);
        check("t3_addressed", {7'd0, addressed}, 8'h00);
        write_byte(8'h55, ack);
        check("t3_data_nack", {7'd0, ack}, 8'h01);
        check("t3_no_rx_valid", 8'(rx_cnt - rx0), 8'd0);
        i2c_stop();
        check("t3_busy_after_stop", {7'd0, busy}, 8'h00);

        // Write 11, repeated START, read 22
        tx_q.push_back(8'h22);
        i2c_start();
        write_byte(8'h84, ack);
        check("t4_addr_ack", {7'd0, ack}, 8'h00);
        write_byte(8'h11, ack);
        check("t4_data_ack", {7'd0, ack}, 8'h00);
        i2c_rstart();
        check("t4_busy_across_sr", {7'd0, busy}, 8'h01);
        write_byte(8'h85, ack);
        check("t4_sr_addr_ack", {7'd0, ack}, 8'h00);
        check("t4_addressed_after_sr", {7'd0, addressed}, 8'h01);
        read_byte(d, 1'b0);
        check("t4_read_byte", d, 8'h22);
        check("t4_rx_data", rx_data, 8'h11);
        i2c_stop();

        // Reset asserted while the data byte is being ACKed
        i2c_start();
        write_byte(8'h84, ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        m_sda = 1'b1;
        wait_clks(H);
        check("t5_ack_driven", {7'd0, sda_oe}, 8'h01);
        #1 rst_n = 1'b0;
        #1;
        check("t5_async_release", {7'd0, sda_oe}, 8'h00);
        check("t5_rst_rx_data", rx_data, 8'h00);
        check("t5_rst_busy", {7'd0, busy}, 8'h00);
        check("t5_rst_addressed", {7'd0, addressed}, 8'h00);
        check("t5_rst_state", {5'd0, state_dbg}, {5'd0, ST_IDLE});
        m_scl = 1'b1;
        wait_clks(H);
        rst_n = 1'b1;
        wait_clks(H);
        i2c_start();
        write_byte(8'h84, ack);
        check("t5_ack_after_reset", {7'd0, ack}, 8'h00);
        check("t5_addressed_after_reset", {7'd0, addressed}, 8'h01);
        i2c_stop();

        // STOP after four data bits
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'h84, ack);
        check("t6_addr_ack", {7'd0, ack}, 8'h00);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        i2c_stop();
        check("t6_state", {5'd0, state_dbg}, {5'd0, ST_IDLE});
        check("t6_busy", {7'd0, busy}, 8'h00);
        check("t6_no_rx_valid", 8'(rx_cnt - rx0), 8'd0);
        check("t6_sda_oe", {7'd0, sda_oe}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
